temporal_spike_encoder: RTL and testbench

- Multi-channel, clocked successor to the single-channel combinational spike generator in the clocked STDP datapath.
- Owns its own gamma-period time counter and holds per-channel spike times in a single-entry shadow buffer, loaded through a valid/ready handshake.
- Each channel emits a step spike (high from its spike time to end of period) or a one-cycle pulse. Optional winner-take-all (WTA) lateral inhibition.
- Drives the input spike bus of the STDP column.

---
 rtl/temporal_spike_encoder.sv | 179 +++++++++++++++++
 tb/tb_temporal_spike_encoder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/temporal_spike_encoder.sv
// Multi-channel temporal spike encoder: a gamma-period counter drives per-channel
// step or pulse spikes from double-buffered spike times, with optional winner-take-all.

module temporal_spike_lane #(
  parameter int T_BITS = 3
) (
  input  logic [T_BITS-1:0] t,
  input  logic [T_BITS-1:0] fire_t,
  input  logic              en,
  input  logic              pulse,
  output logic              raw
);
  assign raw = en && (pulse ? (fire_t == t) : (fire_t <= t));
endmodule

module temporal_spike_encoder #(
  parameter int N_CH   = 8,
  parameter int T_BITS = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic                     continuous_i,
  input  logic                     abort_i,
  input  logic                     pulse_mode_i,
  input  logic                     wta_i,
  input  logic                     load_valid_i,
  output logic                     load_ready_o,
  input  logic [N_CH*T_BITS-1:0]   load_times_i,
  input  logic [N_CH-1:0]          load_en_i,
  output logic [T_BITS:0]          time_o,
  output logic                     running_o,
  output logic [N_CH-1:0]          spike_o,
  output logic                     period_done_o,
  output logic                     winner_valid_o,
  output logic [$clog2(N_CH)-1:0]  winner_idx_o
);
  localparam int PERIOD = 1 << T_BITS;
  localparam int IDX_W  = $clog2(N_CH);
  localparam logic [T_BITS-1:0] T_LAST = T_BITS'(PERIOD - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t                  state_q, state_d;
  logic [T_BITS-1:0]       time_q, time_d;
  logic [N_CH*T_BITS-1:0]  sh_times_q, act_times_q, act_times_d;
  logic [N_CH-1:0]         sh_en_q, act_en_q, act_en_d;
  logic                    sh_full_q;
  logic                    pulse_q, pulse_d, wta_q, wta_d;
  logic                    win_vld_q, win_vld_d;
  logic [IDX_W-1:0]        win_idx_q, win_idx_d, first_idx;
  logic [N_CH-1:0]         spike_q, spike_d, raw_d;
  logic                    done_q, done_d;
  logic                    accept, period_start;

  assign accept = load_valid_i && !sh_full_q;

  always_comb begin
    state_d      = state_q;
    time_d       = time_q;
    act_times_d  = act_times_q;
    act_en_d     = act_en_q;
    pulse_d      = pulse_q;
    wta_d        = wta_q;
    period_start = 1'b0;
    case (state_q)
      S_IDLE: if (start_i && !abort_i) begin
        state_d      = S_RUN;
        time_d       = '0;
        period_start = 1'b1;
      end
      S_RUN: begin
        if (abort_i) begin
          state_d = S_IDLE;
          time_d  = '0;
        end else if (time_q == T_LAST) begin
          time_d = '0;
          if (continuous_i) period_start = 1'b1;
          else              state_d = S_IDLE;
        end else begin
          time_d = time_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Transfer uses the shadow contents as they stand before this edge's load.
    if (period_start) begin
      pulse_d = pulse_mode_i;
      wta_d   = wta_i;
      if (sh_full_q) begin
        act_times_d = sh_times_q;
        act_en_d    = sh_en_q;
      end
    end
  end

  // Raw spikes are evaluated on next-cycle values so registered outputs line up with time_o.
  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    temporal_spike_lane #(.T_BITS(T_BITS)) u_lane (
      .t      (time_d),
      .fire_t (act_times_d[i*T_BITS +: T_BITS]),
      .en     (act_en_d[i]),
      .pulse  (pulse_d),
      .raw    (raw_d[i])
    );
  end

  always_comb begin
    first_idx = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (raw_d[i]) first_idx = IDX_W'(i);
  end

  always_comb begin
    win_vld_d = 1'b0;
    win_idx_d = '0;
    spike_d   = '0;
    if (state_d == S_RUN) begin
      if (win_vld_q && !period_start) begin
        win_vld_d          = 1'b1;
        win_idx_d          = win_idx_q;
        spike_d[win_idx_q] = raw_d[win_idx_q];
      end else if (wta_d && (|raw_d)) begin
        win_vld_d          = 1'b1;
        win_idx_d          = first_idx;
        spike_d[first_idx] = 1'b1;
      end else begin
        spike_d = raw_d;
      end
    end
  end

  assign done_d = (state_d == S_RUN) && (time_d == T_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      time_q      <= '0;
      sh_times_q  <= '0;
      sh_en_q     <= '0;
      sh_full_q   <= 1'b0;
      act_times_q <= '0;
      act_en_q    <= '0;
      pulse_q     <= 1'b0;
      wta_q       <= 1'b0;
      win_vld_q   <= 1'b0;
      win_idx_q   <= '0;
      spike_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      time_q      <= time_d;
      act_times_q <= act_times_d;
      act_en_q    <= act_en_d;
      pulse_q     <= pulse_d;
      wta_q       <= wta_d;
      win_vld_q   <= win_vld_d;
      win_idx_q   <= win_idx_d;
      spike_q     <= spike_d;
      done_q      <= done_d;
      if (accept) begin
        sh_times_q <= load_times_i;
        sh_en_q    <= load_en_i;
        sh_full_q  <= 1'b1;
      end else if (period_start) begin
        sh_full_q  <= 1'b0;
      end
    end
  end

  assign load_ready_o   = !sh_full_q;
  assign time_o         = {1'b0, time_q};
  assign running_o      = (state_q == S_RUN);
  assign spike_o        = spike_q;
  assign period_done_o  = done_q;
  assign winner_valid_o = win_vld_q;
  assign winner_idx_o   = win_idx_q;

endmodule

// File: tb/tb_temporal_spike_encoder.sv
// Scoreboard bench for temporal_spike_encoder (N_CH=4, T_BITS=3): stimulus queues
// hand-computed per-cycle observations, a negedge monitor compares them while running.

module tb_temporal_spike_encoder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 0, continuous_i = 0, abort_i = 0, pulse_mode_i = 0, wta_i = 0;
  logic        load_valid_i = 0;
  logic        load_ready_o;
  logic [11:0] load_times_i = '0;
  logic [3:0]  load_en_i = '0;
  logic [3:0]  time_o;
  logic        running_o;
  logic [3:0]  spike_o;
  logic        period_done_o, winner_valid_o;
  logic [1:0]  winner_idx_o;

  temporal_spike_encoder #(.N_CH(4), .T_BITS(3)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .continuous_i(continuous_i),
    .abort_i(abort_i), .pulse_mode_i(pulse_mode_i), .wta_i(wta_i),
    .load_valid_i(load_valid_i), .load_ready_o(load_ready_o),
    .load_times_i(load_times_i), .load_en_i(load_en_i), .time_o(time_o),
    .running_o(running_o), .spike_o(spike_o), .period_done_o(period_done_o),
    .winner_valid_o(winner_valid_o), .winner_idx_o(winner_idx_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] t; logic [3:0] spk; logic done; logic wv; logic [1:0] widx; logic rdy;
  } obs_t;

  obs_t exp_q[$];
  int   n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic push(input int t, input logic [3:0] spk, input logic wv,
                      input logic [1:0] widx, input logic rdy);
    obs_t e;
    e.t = 4'(t); e.spk = spk; e.done = (t == 7); e.wv = wv; e.widx = widx; e.rdy = rdy;
    exp_q.push_back(e);
  endtask

  // spk nibble k is the expected spike_o at t=k; wv/rdy bit k likewise.
  task automatic push_period(input logic [31:0] spk, input logic [7:0] wv,
                             input logic [1:0] widx, input logic [7:0] rdy);
    for (int t = 0; t < 8; t++) push(t, spk[t*4 +: 4], wv[t], wv[t] ? widx : 2'b0, rdy[t]);
  endtask

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_load(input logic [11:0] times, input logic [3:0] en);
    load_valid_i = 1; load_times_i = times; load_en_i = en;
    step(1);
    load_valid_i = 0;
  endtask

  task automatic do_start(input logic pulse, input logic wta, input logic cont);
    start_i = 1; pulse_mode_i = pulse; wta_i = wta; continuous_i = cont;
    step(1);
    start_i = 0;
  endtask

  // Monitor: running_o acts as the output-valid qualifier.
  always @(negedge clk) begin
    obs_t a, e;
    a = {time_o, spike_o, period_done_o, winner_valid_o, winner_idx_o, load_ready_o};
    if (running_o) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_run @%0t: got running obs %h expected idle", $time, a);
      end else begin
        e = exp_q.pop_front();
        check("run_cycle", 32'(a), 32'(e));
      end
    end else begin
      check("idle_outputs", {time_o, spike_o, period_done_o, winner_valid_o, winner_idx_o}, 32'd0);
    end
  end

  initial begin
    #2;
    check("reset_state", {running_o, time_o, spike_o, period_done_o, winner_valid_o,
                          winner_idx_o, load_ready_o}, 32'd1);
    #10 rst_n = 1;
    step(1);

    // Step mode, times {3,0,7,5}; mode inputs flipped mid-period must not matter
    do_load({3'd5, 3'd7, 3'd0, 3'd3}, 4'b1111);
    push_period(32'hFBB33222, 8'h00, 2'd0, 8'hFF);
    do_start(0, 0, 0);
    pulse_mode_i = 1; wta_i = 1;
    step(8);

    // Pulse mode, no reload: active times retained
    push_period(32'h40801002, 8'h00, 2'd0, 8'hFF);
    do_start(1, 0, 0);
    step(8);

    // Partial enables
    do_load({3'd2, 3'd2, 3'd2, 3'd2}, 4'b0101);
    push_period(32'h55555500, 8'h00, 2'd0, 8'hFF);
    do_start(0, 0, 0);
    step(8);

    // WTA step: ch1 and ch2 tie at t2, lowest index wins
    do_load({3'd6, 3'd2, 3'd2, 3'd4}, 4'b1111);
    push_period(32'h22222200, 8'hFC, 2'd1, 8'hFF);
    do_start(0, 1, 0);
    step(8);

    // WTA pulse on retained times: winner pulses once, outputs hold
    push_period(32'h00000200, 8'hFC, 2'd1, 8'hFF);
    do_start(1, 1, 0);
    step(8);

    // Continuous: A before start, B accepted at t3, B used in period 2, no gap
    do_load({3'd0, 3'd0, 3'd0, 3'd0}, 4'b0001);
    push_period(32'h11111111, 8'h00, 2'd0, 8'h0F);
    push_period(32'h80000000, 8'h00, 2'd0, 8'hFF);
    do_start(0, 0, 1);
    for (int k = 0; k < 16; k++) begin
      load_valid_i = (k == 3);
      if (k == 3) begin load_times_i = {3'd7, 3'd7, 3'd7, 3'd7}; load_en_i = 4'b1000; end
      continuous_i = (k < 8);
      step(1);
    end
    load_valid_i = 0; continuous_i = 0;

    // Abort at t4 with a pending shadow load D
    do_load({3'd3, 3'd2, 3'd1, 3'd0}, 4'b1111);
    push(0, 4'b0001, 0, 0, 1);
    push(1, 4'b0011, 0, 0, 1);
    push(2, 4'b0111, 0, 0, 0);
    push(3, 4'b1111, 0, 0, 0);
    push(4, 4'b1111, 0, 0, 0);
    do_start(0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      load_valid_i = (k == 1);
      if (k == 1) begin load_times_i = {3'd6, 3'd6, 3'd6, 3'd6}; load_en_i = 4'b0010; end
      abort_i = (k == 4);
      step(1);
    end
    load_valid_i = 0; abort_i = 0;
    check("shadow_kept_after_abort", {31'd0, load_ready_o}, 32'd0);
    start_i = 1; abort_i = 1;
    step(1);
    start_i = 0; abort_i = 0;
    check("start_abort_stays_idle", {31'd0, running_o}, 32'd0);
    push_period(32'h22000000, 8'h00, 2'd0, 8'hFF);
    do_start(0, 0, 0);
    step(8);

    // Reset asserted mid-RUN (during t2, before its monitor sample)
    push(0, 4'b0000, 0, 0, 1);
    push(1, 4'b0000, 0, 0, 1);
    do_start(0, 0, 0);
    step(2);
    rst_n = 0;
    #1;
    check("reset_mid_run", {running_o, time_o, spike_o, period_done_o, winner_valid_o,
                            winner_idx_o, load_ready_o}, 32'd1);
    #5 rst_n = 1;
    step(3);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
